// File: rtl/texture_ram.sv
// Loadable wall-texture memory: byte-stream loader fills the RAM after reset,
// then a two-stage pipelined read port returns one (optionally shaded) texel per clock.
module texture_ram #(
  parameter int CHANNEL_BITS = 2,
  parameter int TEX_BITS     = 6,
  parameter int TEXID_BITS   = 1,
  parameter int SHADE_MODE   = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_start_i,
  input  logic                      load_valid_i,
  input  logic [7:0]                load_data_i,
  output logic                      load_busy_o,
  output logic                      loaded_o,
  input  logic                      rd_req_i,
  input  logic [TEXID_BITS-1:0]     rd_tex_i,
  input  logic [TEX_BITS-1:0]       rd_col_i,
  input  logic [TEX_BITS-1:0]       rd_row_i,
  input  logic                      rd_side_i,
  output logic                      rd_valid_o,
  output logic [3*CHANNEL_BITS-1:0] rd_val_o
);

  localparam int W     = 3 * CHANNEL_BITS;
  localparam int A     = TEXID_BITS + 2 * TEX_BITS;
  localparam int DEPTH = 1 << A;

  // state | meaning
  // IDLE  | not loading; load_valid ignored, waits for load_start
  // LOAD  | each load_valid byte is written at waddr, last address ends the load
  typedef enum logic {IDLE, LOAD} state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   waddr_q, waddr_d;
  logic           loaded_q, loaded_d;
  logic           wr_en;

  logic [W-1:0]   mem_q [DEPTH];
  logic [A-1:0]   raddr;
  logic [W-1:0]   rdata_q;

  logic           s1_req_q, s1_side_q, s1_gate_q;
  logic [W-1:0]   shaded;
  logic           rd_valid_q;
  logic [W-1:0]   rd_val_q, rd_val_d;

  logic           unused_load_bits;
  assign unused_load_bits = ^load_data_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    loaded_d = loaded_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d  = LOAD;
          waddr_d  = '0;
          loaded_d = 1'b0;
        end
      end
      LOAD: begin
        // A start in the same cycle as a data byte restarts and drops the byte.
        if (load_start_i) begin
          waddr_d  = '0;
          loaded_d = 1'b0;
        end else if (load_valid_i) begin
          wr_en   = 1'b1;
          waddr_d = waddr_q + A'(1);
          if (waddr_q == '1) begin
            state_d  = IDLE;
            loaded_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_busy_o = (state_q == LOAD);
  assign loaded_o    = loaded_q;

  // Column-major texel addressing: row occupies the LSBs.
  assign raddr = {rd_tex_i, rd_col_i, rd_row_i};

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[waddr_q] <= load_data_i[W-1:0];
    end
    rdata_q <= mem_q[raddr];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_req_q  <= 1'b0;
      s1_side_q <= 1'b0;
      s1_gate_q <= 1'b0;
    end else begin
      s1_req_q  <= rd_req_i;
      s1_side_q <= rd_side_i;
      s1_gate_q <= loaded_q && !load_busy_o;
    end
  end

  always_comb begin
    shaded = '0;
    for (int c = 0; c < 3; c++) begin
      shaded[c*CHANNEL_BITS +: CHANNEL_BITS] = rdata_q[c*CHANNEL_BITS +: CHANNEL_BITS] >> 1;
    end
  end

  always_comb begin
    rd_val_d = rd_val_q;
    if (s1_req_q) begin
      if (!s1_gate_q) begin
        rd_val_d = '0;
      end else if ((SHADE_MODE != 0) && s1_side_q) begin
        rd_val_d = shaded;
      end else begin
        rd_val_d = rdata_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_val_q   <= '0;
    end else begin
      rd_valid_q <= s1_req_q;
      rd_val_q   <= rd_val_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_val_o   = rd_val_q;

endmodule

// File: tb/tb_texture_ram.sv
// Bench for texture_ram: a shaded and an unshaded instance share stimulus and
// are checked against an array model of the texture image and loader status.
module tb_texture_ram;

  localparam int DEPTH = 8192;

  logic       clk_i = 1'b0;
  logic       reset_i, load_start_i, load_valid_i;
  logic [7:0] load_data_i;
  logic       rd_req_i, rd_side_i;
  logic [0:0] rd_tex_i;
  logic [5:0] rd_col_i, rd_row_i;

  logic       busy_a, loaded_a, valid_a;
  logic [5:0] val_a;
  logic       busy_b, loaded_b, valid_b;
  logic [5:0] val_b;

  texture_ram #(.SHADE_MODE(1)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .load_start_i(load_start_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_busy_o(busy_a), .loaded_o(loaded_a), .rd_req_i(rd_req_i),
    .rd_tex_i(rd_tex_i), .rd_col_i(rd_col_i), .rd_row_i(rd_row_i),
    .rd_side_i(rd_side_i), .rd_valid_o(valid_a), .rd_val_o(val_a)
  );

  texture_ram #(.SHADE_MODE(0)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .load_start_i(load_start_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_busy_o(busy_b), .loaded_o(loaded_b), .rd_req_i(rd_req_i),
    .rd_tex_i(rd_tex_i), .rd_col_i(rd_col_i), .rd_row_i(rd_row_i),
    .rd_side_i(rd_side_i), .rd_valid_o(valid_b), .rd_val_o(val_b)
  );

  always #5 clk_i = ~clk_i;

  logic [5:0] model_mem [DEPTH];
  int         model_waddr;
  bit         model_loaded, model_busy;
  int         errors, checks;

  int         rq_addr[$];
  bit         rq_side[$];
  bit         rq_req[$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [5:0] exp_val(int a, bit side, bit shade, bit gate);
    int t, r, g, b;
    if (!gate) return 6'd0;
    t = int'(model_mem[a]);
    r = t / 16;
    g = (t / 4) % 4;
    b = t % 4;
    if (shade && side) return 6'((r / 2) * 16 + (g / 2) * 4 + (b / 2));
    return 6'(t);
  endfunction

  task automatic push_rd(int a, bit side, bit req);
    rq_addr.push_back(a);
    rq_side.push_back(side);
    rq_req.push_back(req);
  endtask

  // Drains the request queues one per cycle; result of request j is due
  // after the second rising edge following the cycle it was driven in.
  task automatic run_pipe(string name);
    int         n, a;
    bit         gate;
    bit         ev[$];
    logic [5:0] ea[$], eb[$];
    n = rq_addr.size();
    for (int i = 0; i <= n + 1; i++) begin
      if (i < n) begin
        a         = rq_addr[i];
        rd_req_i  = rq_req[i];
        rd_tex_i  = 1'(a / 4096);
        rd_col_i  = 6'(a / 64);
        rd_row_i  = 6'(a);
        rd_side_i = rq_side[i];
        gate      = model_loaded && !model_busy;
        ev.push_back(rq_req[i]);
        ea.push_back(exp_val(a, rq_side[i], 1'b1, gate));
        eb.push_back(exp_val(a, rq_side[i], 1'b0, gate));
      end else begin
        rd_req_i  = 1'b0;
        rd_side_i = 1'b0;
      end
      tick();
      if (i >= 1 && i - 1 < n) begin
        checks++;
        if (valid_a !== ev[i-1] || valid_b !== ev[i-1]) begin
          errors++;
          $display("FAIL %s valid[%0d] got a=%b b=%b exp=%b", name, i-1, valid_a, valid_b, ev[i-1]);
        end
        if (ev[i-1]) begin
          checks++;
          if (val_a !== ea[i-1] || val_b !== eb[i-1]) begin
            errors++;
            $display("FAIL %s val[%0d] got a=%h b=%h exp a=%h b=%h", name, i-1, val_a, val_b, ea[i-1], eb[i-1]);
          end
        end
      end
    end
    checks++;
    if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_valid got a=%b b=%b exp=0", name, valid_a, valid_b);
    end
    rq_addr.delete();
    rq_side.delete();
    rq_req.delete();
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    model_waddr  = 0;
    model_loaded = 1'b0;
    model_busy   = 1'b1;
    checks++;
    if (busy_a !== 1'b1 || loaded_a !== 1'b0) begin
      errors++;
      $display("FAIL start_load got busy=%b loaded=%b exp busy=1 loaded=0", busy_a, loaded_a);
    end
  endtask

  // kind 0: byte k = k[5:0] ^ (k>>7)[5:0]; kind 1: random texels.
  task automatic load_bytes(int n, int kind);
    logic [5:0] texel;
    int         hi;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        load_valid_i = 1'b0;
        load_data_i  = 8'($urandom);
        tick();
      end
      hi    = k >> 7;
      texel = (kind == 0) ? (6'(k) ^ 6'(hi)) : 6'($urandom);
      if (model_waddr == DEPTH - 1) begin
        checks++;
        if (loaded_a !== 1'b0 || busy_a !== 1'b1) begin
          errors++;
          $display("FAIL loaded_early got loaded=%b busy=%b exp loaded=0 busy=1", loaded_a, busy_a);
        end
      end
      load_valid_i = 1'b1;
      load_data_i  = {2'($urandom_range(0, 3)), texel};
      model_mem[model_waddr] = texel;
      tick();
      model_waddr++;
      if (model_waddr == DEPTH) begin
        model_waddr  = 0;
        model_loaded = 1'b1;
        model_busy   = 1'b0;
        checks++;
        if (loaded_a !== 1'b1 || busy_a !== 1'b0 || loaded_b !== 1'b1) begin
          errors++;
          $display("FAIL load_done got loaded=%b/%b busy=%b exp loaded=1 busy=0", loaded_a, loaded_b, busy_a);
        end
      end
    end
    load_valid_i = 1'b0;
  endtask

  task automatic random_reads(string name, int n);
    for (int i = 0; i < n; i++) begin
      push_rd(int'($urandom_range(0, DEPTH - 1)), 1'($urandom), ($urandom_range(0, 3) != 0));
    end
    run_pipe(name);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    model_loaded = 1'b0;
    model_busy   = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || val_a !== 6'd0 || busy_a !== 1'b0 || loaded_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got valid=%b val=%h busy=%b loaded=%b exp all 0", valid_a, val_a, busy_a, loaded_a);
    end
    checks++;
    if (valid_b !== 1'b0 || val_b !== 6'd0 || busy_b !== 1'b0 || loaded_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_b got valid=%b val=%h busy=%b loaded=%b exp all 0", valid_b, val_b, busy_b, loaded_b);
    end
    push_rd(int'($urandom_range(0, DEPTH - 1)), 1'b0, 1'b1);
    push_rd(int'($urandom_range(0, DEPTH - 1)), 1'b1, 1'b1);
    run_pipe("read_before_load");
  endtask

  task automatic test_full_load();
    start_load();
    load_bytes(DEPTH, 0);
    push_rd(32'h1149, 1'b0, 1'b1);
    run_pipe("read_1149");
  endtask

  task automatic test_shading();
    rd_req_i = 1'b1; rd_tex_i = 1'b0; rd_col_i = 6'd0; rd_row_i = 6'd57; rd_side_i = 1'b1;
    tick();
    rd_side_i = 1'b0;
    tick();
    rd_req_i = 1'b0;
    checks++;
    if (val_a !== 6'b01_01_00 || val_b !== 6'b11_10_01) begin
      errors++;
      $display("FAIL shade_side1 got a=%b b=%b exp a=010100 b=111001", val_a, val_b);
    end
    tick();
    checks++;
    if (val_a !== 6'b11_10_01 || val_b !== 6'b11_10_01) begin
      errors++;
      $display("FAIL shade_side0 got a=%b b=%b exp a=111001 b=111001", val_a, val_b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int base;
    base = int'($urandom_range(0, DEPTH - 1));
    push_rd(base, 1'b0, 1'b1);
    push_rd((base + 1000) % DEPTH, 1'b1, 1'b1);
    push_rd((base + 2000) % DEPTH, 1'b0, 1'b1);
    run_pipe("back_to_back");
  endtask

  task automatic test_restart();
    start_load();
    load_bytes(100, 1);
    load_start_i = 1'b1;
    load_valid_i = 1'b1;
    load_data_i  = 8'($urandom);
    tick();
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    model_waddr  = 0;
    checks++;
    if (busy_a !== 1'b1 || loaded_a !== 1'b0) begin
      errors++;
      $display("FAIL restart_state got busy=%b loaded=%b exp busy=1 loaded=0", busy_a, loaded_a);
    end
    load_bytes(DEPTH, 1);
    for (int a = 0; a < 100; a++) push_rd(a, 1'($urandom), 1'b1);
    run_pipe("restart_low_addrs");
  endtask

  task automatic test_reset_mid_load();
    start_load();
    load_bytes(500, 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    model_busy   = 1'b0;
    model_loaded = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || loaded_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load got busy=%b loaded=%b exp 0 0", busy_a, loaded_a);
    end
    random_reads("reads_after_reset", 20);
    start_load();
    load_bytes(DEPTH, 1);
    random_reads("reads_after_reload", 40);
  endtask

  task automatic test_reset_mid_read();
    rd_req_i = 1'b1;
    rd_tex_i = 1'b1; rd_col_i = 6'd3; rd_row_i = 6'd7; rd_side_i = 1'b0;
    tick();
    tick();
    reset_i  = 1'b1;
    rd_req_i = 1'b0;
    tick();
    reset_i  = 1'b0;
    model_loaded = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read got valid a=%b b=%b exp 0", valid_a, valid_b);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_i = 1'b1; load_start_i = 1'b0; load_valid_i = 1'b0; load_data_i = 8'd0;
    rd_req_i = 1'b0; rd_side_i = 1'b0; rd_tex_i = 1'b0; rd_col_i = 6'd0; rd_row_i = 6'd0;
    model_waddr = 0; model_loaded = 1'b0; model_busy = 1'b0;
    test_reset();
    test_full_load();
    test_shading();
    test_back_to_back();
    random_reads("random_reads", 60);
    test_restart();
    test_reset_mid_load();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/texture_ram.md
# texture_ram

Loadable, parametrised wall-texture memory with a pipelined read port, replacing the sim-populated texture ROM. A byte-stream loader writes texel data after reset. Once the load completes, the row renderer reads one texel per clock, indexed by texture ID, column and row. An optional shading mode darkens texels for the side face.

## Interface
- CHANNEL_BITS, 2, bits per colour channel; texel width W = 3*CHANNEL_BITS, packed {R,G,B} from MSB.
- TEX_BITS, 6, bits per texel coordinate; each texture is 2^TEX_BITS x 2^TEX_BITS texels.
- TEXID_BITS, 1, texture ID bits; 2^TEXID_BITS textures.
- SHADE_MODE, 1, 1 = halve every channel when rd_side=1; 0 = rd_side ignored.
- Derived: A = TEXID_BITS + 2*TEX_BITS address bits; DEPTH = 2^A entries (defaults: 13, 8192).
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- load_start, in, 1, pulse; (re)starts a load at address 0.
- load_valid, in, 1, load_data is valid this cycle.
- load_data, in, 8, one texel per byte; bits [W-1:0] are stored, upper bits are ignored.
- load_busy, out, 1, loader is in LOAD.
- loaded, out, 1, a complete image has been loaded since the last reset or start.
- rd_req, in, 1, read request this cycle.
- rd_tex, in, TEXID_BITS, texture ID.
- rd_col, in, TEX_BITS, texel column.
- rd_row, in, TEX_BITS, texel row.
- rd_side, in, 1, side flag used for shading.
- rd_valid, out, 1, rd_val holds the result of the request made 2 cycles earlier.
- rd_val, out, W, texel colour.

## Operation
- Storage: DEPTH x W single-port write, synchronous-read RAM.
  - Address = {tex, col, row}, column-major: row is the LSBs.
  - Reset does not clear contents.
- Loader FSM has two states, IDLE and LOAD.
  - IDLE: load_start → LOAD; waddr=0; loaded←0. load_valid is ignored.
  - LOAD: each load_valid cycle writes load_data[W-1:0] to mem[waddr], then waddr increments.
  - LOAD: a write at waddr=DEPTH-1 → IDLE; loaded←1; waddr wraps to 0.
  - LOAD: load_start → restart at waddr=0. loaded stays 0. A load_valid byte in the same cycle is discarded (start has priority).
  - load_busy = (state==LOAD).
- Read pipeline (2 stages):
  - S1 registers the RAM output, rd_side, rd_req, and the gate (loaded && !load_busy) sampled in the request cycle.
  - S2 registers the output: rd_valid←S1.req.
  - S2 rd_val: if S1 gate=0 → 0; else if SHADE_MODE and S1 side → each channel shifted right by 1 (per channel, no cross-channel carry); else raw texel.
  - When rd_req=0, S2 still registers rd_valid=0. rd_val is then don't-care, but the implementation holds its last value.
- Reads and loader writes may occur in the same cycle. The gate forces the read result to 0, so there is no read-during-write hazard visible at the output.

## Timing
- Reset values: rd_valid=0, rd_val=0, load_busy=0, loaded=0, state=IDLE, waddr=0.
- Read latency is exactly 2 cycles: request at edge N gives rd_valid=1 and rd_val after edge N+2.
- Throughput is one read per cycle, with no stalls and no backpressure.
- Load rate is one byte per load_valid cycle. A full load takes DEPTH valid cycles; gaps in load_valid are allowed.
- load_busy rises the cycle after load_start. loaded rises the cycle after the final write.
- Reset mid-load: → IDLE with loaded=0. Partially written contents remain; the next load overwrites them.
- Reset mid-read: in-flight reads are dropped; rd_valid=0 on the next cycle.
- Reads in the 2 cycles following loaded↑ return real data. The gate is sampled at request time, so earlier requests return 0.

## Test plan
- Reset, then idle → rd_valid=0, rd_val=0, load_busy=0, loaded=0; rd_req before any load → rd_valid=1 after 2 cycles with rd_val=0.
- Full load (defaults, 8192 bytes), byte k = k[5:0] ^ (k>>7)[5:0] → loaded=1 exactly one cycle after the last byte. Then read (tex=1, col=5, row=9) → rd_val = the stored byte for address 0x1149.
- Back-to-back reads on consecutive cycles with 3 distinct addresses → 3 consecutive rd_valid cycles, correct values in order, each 2 cycles after its request.
- Shading: stored texel 6'b11_10_01, rd_side=1 → 6'b01_01_00; rd_side=0 → 6'b11_10_01. With SHADE_MODE=0 → 6'b11_10_01 both ways.
- Restart: load 100 bytes, assert load_start together with load_valid → that byte is discarded, waddr=0, loaded=0. Complete the load → loaded=1, and addresses 0–99 hold the new data.
- Reset after 500 load bytes → load_busy=0, loaded=0; reads return 0 until a new full load completes.
